// File: rtl/arp_tx_pkg.sv
// ARP constants and helpers shared by the ARP transmitter and receiver.
//   HTYPE/PTYPE/HLEN/PLEN  fixed Ethernet/IPv4 ARP header fields
//   OPER_REQ/OPER_REPLY    opcode values
//   ARP_LEN/FRAME_LEN      ARP payload bytes / padded frame bytes
//   BCAST_MAC              Ethernet broadcast address
//   arp_byte()             byte idx (0-based, MSB first) of an ARP frame
package arp_tx_pkg;

    localparam logic [15:0] HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  HLEN_ETH   = 8'd6;
    localparam logic [7:0]  PLEN_IPV4  = 8'd4;
    localparam logic [15:0] OPER_REQ   = 16'd1;
    localparam logic [15:0] OPER_REPLY = 16'd2;
    localparam int          ARP_LEN    = 28;
    localparam int          FRAME_LEN  = 46;
    localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } tx_state_t;

    // Bytes past the ARP payload are padding and read as zero.
    function automatic logic [7:0] arp_byte(
        input logic [5:0]  idx,
        input logic [15:0] oper,
        input logic [47:0] smac,
        input logic [31:0] sip,
        input logic [47:0] tmac,
        input logic [31:0] tip
    );
        logic [223:0] hdr;
        hdr = {HTYPE_ETH, PTYPE_IPV4, HLEN_ETH, PLEN_IPV4, oper, smac, sip, tmac, tip};
        if (idx >= 6'(ARP_LEN)) return 8'h00;
        hdr = hdr << {idx, 3'b000};
        return hdr[223:216];
    endfunction

endpackage

// File: rtl/arp_tx.sv
// ARP transmitter: builds 46-byte ARP REPLY / REQUEST frames and streams them
// byte-by-byte to the MAC layer, with a fixed idle gap between frames.
//   i_clk, i_rst_n                   clock, synchronous active-low reset
//   i_src_ip, i_src_ip_valid         runtime local-IP override
//   i_trig_reply, i_dst_mac, i_dst_ip   reply job (requester MAC/IP)
//   i_active_req, i_active_ip        request job (IP to resolve)
//   o_mac_data/o_mac_valid/o_mac_last   byte stream, no backpressure
//   o_eth_dst_mac                    Ethernet destination of current frame
//   o_busy                           high from first byte through end of gap
module arp_tx
    import arp_tx_pkg::*;
#(
    parameter logic [31:0] P_SRC_IP  = 32'hC0A8_0A01,
    parameter logic [47:0] P_SRC_MAC = 48'h0000_0000_0000,
    parameter int unsigned P_GAP     = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_src_ip,
    input  logic        i_src_ip_valid,
    input  logic        i_trig_reply,
    input  logic [47:0] i_dst_mac,
    input  logic [31:0] i_dst_ip,
    input  logic        i_active_req,
    input  logic [31:0] i_active_ip,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_valid,
    output logic        o_mac_last,
    output logic [47:0] o_eth_dst_mac,
    output logic        o_busy
);

    localparam logic [7:0] GAP_LAST = 8'(P_GAP - 1);
    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    tx_state_t   state;
    logic [5:0]  cnt;
    logic [7:0]  gap_cnt;
    logic        pend_reply, pend_req;
    logic [47:0] reply_mac;
    logic [31:0] reply_ip, req_ip, local_ip;
    logic [15:0] cur_oper;
    logic [47:0] cur_tmac;
    logic [31:0] cur_sip, cur_tip;

    logic        start, pick_reply;
    logic [15:0] nxt_oper;
    logic [47:0] nxt_tmac;
    logic [31:0] nxt_tip;
    logic [5:0]  cnt_nxt;

    // A pending job starts from IDLE, or straight out of the last gap cycle so
    // back-to-back frames are separated by exactly P_GAP idle cycles.
    assign start      = (pend_reply | pend_req) &
                        ((state == ST_IDLE) || (state == ST_GAP && gap_cnt == GAP_LAST));
    assign pick_reply = pend_reply;
    assign nxt_oper   = pick_reply ? OPER_REPLY : OPER_REQ;
    assign nxt_tmac   = pick_reply ? reply_mac : 48'h0;
    assign nxt_tip    = pick_reply ? reply_ip : req_ip;
    assign cnt_nxt    = cnt + 6'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            gap_cnt       <= '0;
            pend_reply    <= 1'b0;
            pend_req      <= 1'b0;
            reply_mac     <= '0;
            reply_ip      <= '0;
            req_ip        <= '0;
            local_ip      <= P_SRC_IP;
            cur_oper      <= '0;
            cur_tmac      <= '0;
            cur_sip       <= '0;
            cur_tip       <= '0;
            o_mac_data    <= '0;
            o_mac_valid   <= 1'b0;
            o_mac_last    <= 1'b0;
            o_eth_dst_mac <= '0;
            o_busy        <= 1'b0;
        end else begin
            if (i_src_ip_valid) local_ip <= i_src_ip;
            if (i_trig_reply) begin
                reply_mac <= i_dst_mac;
                reply_ip  <= i_dst_ip;
            end
            if (i_active_req) req_ip <= i_active_ip;

            // A trigger on the same edge its job is consumed re-arms the flag
            // with the fresh fields.
            pend_reply <= i_trig_reply | (pend_reply & ~(start & pick_reply));
            pend_req   <= i_active_req | (pend_req & ~(start & ~pick_reply));

            if (start) begin
                state         <= ST_SEND;
                cnt           <= '0;
                cur_oper      <= nxt_oper;
                cur_tmac      <= nxt_tmac;
                cur_tip       <= nxt_tip;
                cur_sip       <= local_ip;
                o_mac_data    <= arp_byte(6'd0, nxt_oper, P_SRC_MAC, local_ip, nxt_tmac, nxt_tip);
                o_mac_valid   <= 1'b1;
                o_mac_last    <= 1'b0;
                o_eth_dst_mac <= pick_reply ? reply_mac : BCAST_MAC;
                o_busy        <= 1'b1;
            end else begin
                case (state)
                    ST_SEND: begin
                        if (cnt == LAST_IDX) begin
                            state       <= ST_GAP;
                            gap_cnt     <= '0;
                            o_mac_data  <= '0;
                            o_mac_valid <= 1'b0;
                            o_mac_last  <= 1'b0;
                        end else begin
                            cnt        <= cnt_nxt;
                            o_mac_data <= arp_byte(cnt_nxt, cur_oper, P_SRC_MAC,
                                                   cur_sip, cur_tmac, cur_tip);
                            o_mac_last <= (cnt_nxt == LAST_IDX);
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx: directed scenarios plus randomized jobs,
// checked against a frame-level model (pending job slots, expected byte
// arrays built from the ARP field layout, inter-frame gap rule).
module tb_arp_tx;
    localparam logic [31:0] SRC_IP  = 32'hC0A8_0A01;
    localparam logic [47:0] SRC_MAC = 48'h0200_5E10_2030;
    localparam int          GAP     = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_ip;
    logic        src_ip_valid;
    logic        trig_reply;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic        active_req;
    logic [31:0] active_ip;
    logic [7:0]  o_mac_data;
    logic        o_mac_valid, o_mac_last, o_busy;
    logic [47:0] o_eth_dst_mac;

    arp_tx #(.P_SRC_IP(SRC_IP), .P_SRC_MAC(SRC_MAC), .P_GAP(GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_src_ip(src_ip), .i_src_ip_valid(src_ip_valid),
        .i_trig_reply(trig_reply), .i_dst_mac(dst_mac), .i_dst_ip(dst_ip),
        .i_active_req(active_req), .i_active_ip(active_ip),
        .o_mac_data(o_mac_data), .o_mac_valid(o_mac_valid), .o_mac_last(o_mac_last),
        .o_eth_dst_mac(o_eth_dst_mac), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // model state
    bit          s_rep_v, s_req_v;
    logic [47:0] s_rep_mac;
    logic [31:0] s_rep_ip, s_req_ip, m_local_ip;
    logic [7:0]  exp_f [0:45];
    logic [47:0] exp_dst;
    bit          in_frame, have_prev, exact_gap;
    int          idx, idle_cnt, frames_done;

    task automatic build(input bit rep, input logic [47:0] tmac, input logic [31:0] tip);
        exp_f[0] = 8'h00; exp_f[1] = 8'h01; exp_f[2] = 8'h08; exp_f[3] = 8'h00;
        exp_f[4] = 8'd6;  exp_f[5] = 8'd4;  exp_f[6] = 8'h00;
        exp_f[7] = rep ? 8'h02 : 8'h01;
        for (int i = 0; i < 6; i++) begin
            exp_f[8 + i]  = 8'(SRC_MAC >> (8 * (5 - i)));
            exp_f[18 + i] = rep ? 8'(tmac >> (8 * (5 - i))) : 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            exp_f[14 + i] = 8'(m_local_ip >> (8 * (3 - i)));
            exp_f[24 + i] = 8'(tip >> (8 * (3 - i)));
        end
        for (int i = 28; i < 46; i++) exp_f[i] = 8'h00;
        exp_dst = rep ? tmac : 48'hFFFF_FFFF_FFFF;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame  = 0;
                have_prev = 0;
                idle_cnt  = 0;
            end else if (o_mac_valid) begin
                if (!in_frame) begin
                    chk("frame_expected", 64'(s_rep_v || s_req_v), 1);
                    if (s_rep_v) begin
                        build(1, s_rep_mac, s_rep_ip);
                        s_rep_v = 0;
                    end else begin
                        build(0, 48'h0, s_req_ip);
                        s_req_v = 0;
                    end
                    if (have_prev) begin
                        if (exact_gap) chk("gap_exact", idle_cnt, GAP);
                        else chk("gap_min", 64'(idle_cnt >= GAP), 1);
                    end
                    in_frame = 1;
                    idx = 0;
                end
                chk($sformatf("byte%0d", idx), o_mac_data, exp_f[idx]);
                chk($sformatf("last%0d", idx), o_mac_last, 64'(idx == 45));
                chk("eth_dst", o_eth_dst_mac, exp_dst);
                if (o_mac_last || idx == 45) begin
                    in_frame    = 0;
                    frames_done++;
                    have_prev   = 1;
                    exact_gap   = s_rep_v || s_req_v;
                    idle_cnt    = 0;
                end else begin
                    idx++;
                end
            end else begin
                if (in_frame) begin
                    chk("truncated", idx, 46);
                    in_frame = 0;
                end
                chk("idle_out", {o_mac_data, o_mac_last}, 0);
                idle_cnt++;
            end
        end
    endtask

    // Called just after a rising edge; holds the pulses for one cycle.
    task automatic pulse(input bit rep, input logic [47:0] dmac, input logic [31:0] dip,
                         input bit req, input logic [31:0] aip,
                         input bit ov, input logic [31:0] sip);
        trig_reply = rep; dst_mac = dmac; dst_ip = dip;
        active_req = req; active_ip = aip;
        src_ip_valid = ov; src_ip = sip;
        if (rep) begin s_rep_v = 1; s_rep_mac = dmac; s_rep_ip = dip; end
        if (req) begin s_req_v = 1; s_req_ip = aip; end
        if (ov) m_local_ip = sip;
        @(posedge clk); #1;
        trig_reply = 0; active_req = 0; src_ip_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((o_busy || s_rep_v || s_req_v || in_frame) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 2000) chk("idle_timeout", t, 0);
    endtask

    task automatic wait_byte(input int k);
        int t = 0;
        while (!(o_mac_valid && in_frame && idx == k) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 300) chk($sformatf("wait_byte%0d_timeout", k), t, 0);
    endtask

    task automatic wait_last();
        int t = 0;
        while (!o_mac_last && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 300) chk("last_timeout", t, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd;
        rst_n = 0; src_ip = 0; src_ip_valid = 0; trig_reply = 0; dst_mac = 0;
        dst_ip = 0; active_req = 0; active_ip = 0;
        s_rep_v = 0; s_req_v = 0; s_rep_mac = 0; s_rep_ip = 0; s_req_ip = 0;
        m_local_ip = SRC_IP; in_frame = 0; have_prev = 0; exact_gap = 0;
        idx = 0; idle_cnt = 0; frames_done = 0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_mac_valid, 0);
        chk("rst_last", o_mac_last, 0);
        chk("rst_data", o_mac_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_dst", o_eth_dst_mac, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // reply frame, first-byte latency, busy through the gap
        pulse(1, 48'h0211_2233_4455, 32'hC0A8_0A00, 0, 0, 0, 0);
        chk("lat_edge_n", o_mac_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge_n1", o_mac_valid, 1);
        wait_last();
        repeat (GAP) @(posedge clk);
        #1;
        chk("busy_gap_end", o_busy, 1);
        @(posedge clk); #1;
        chk("busy_after_gap", o_busy, 0);
        wait_idle();

        // request frame
        pulse(0, 0, 0, 1, 32'hC0A8_0A07, 0, 0);
        wait_idle();

        // simultaneous reply + request
        fd = frames_done;
        pulse(1, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0A22, 1, 32'hC0A8_0A33, 0, 0);
        wait_idle();
        chk("simul_frames", frames_done - fd, 2);

        // reply queued at byte 20 of an ongoing request
        fd = frames_done;
        pulse(0, 0, 0, 1, 32'hC0A8_0A44, 0, 0);
        wait_byte(20);
        pulse(1, 48'h0211_2233_4466, 32'hC0A8_0A55, 0, 0, 0, 0);
        wait_idle();
        chk("queued_frames", frames_done - fd, 2);

        // local IP override mid-frame applies to the next frame only
        pulse(1, 48'h0211_2233_4477, 32'hC0A8_0A66, 0, 0, 0, 0);
        wait_byte(10);
        pulse(0, 0, 0, 0, 0, 1, 32'hC0A8_0A09);
        wait_idle();
        pulse(0, 0, 0, 1, 32'hC0A8_0A08, 0, 0);
        wait_idle();

        // reset mid-frame drops current frame and pending request
        pulse(1, 48'h0211_2233_4488, 32'hC0A8_0A77, 0, 0, 0, 0);
        wait_byte(5);
        pulse(0, 0, 0, 1, 32'hC0A8_0A99, 0, 0);
        wait_byte(30);
        fd = frames_done;
        rst_n = 0;
        s_rep_v = 0; s_req_v = 0; m_local_ip = SRC_IP;
        @(posedge clk); #1;
        chk("mrst_valid", o_mac_valid, 0);
        chk("mrst_last", o_mac_last, 0);
        chk("mrst_data", o_mac_data, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_dst", o_eth_dst_mac, 0);
        rst_n = 1;
        repeat (60) @(posedge clk);
        #1;
        chk("mrst_no_frame", frames_done, fd);

        // randomized jobs, some with mid-frame triggers/overrides
        for (int it = 0; it < 20; it++) begin
            bit rep, req, ov;
            wait_idle();
            rep = 1'($urandom % 2);
            req = rep ? 1'($urandom % 2) : 1'b1;
            ov  = ($urandom % 4) == 0;
            pulse(rep, {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF, $urandom,
                  req, $urandom, ov, $urandom);
            if ($urandom % 2) begin
                wait_byte(int'($urandom_range(1, 38)));
                rep = 1'($urandom % 2);
                pulse(rep, {$urandom, $urandom}, $urandom, ~rep | 1'($urandom % 2),
                      $urandom, 1'($urandom % 2), $urandom);
                if ($urandom % 3 == 0)
                    pulse(rep, {$urandom, $urandom}, $urandom, ~rep, $urandom, 0, 0);
            end
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
